// File: rtl/tanh_sched_pkg.sv
// Shared definitions for the tanh PLA scheduler.
//   state_e    : scheduler FSM encoding (IDLE / ACTIVE / DRAIN)
//   clog2_f    : ceiling log2 with a minimum of 1, used for ID and pointer widths
//   ONE_HALF   : 0.5 in the PLA output format at the default W_OUT
//   one_half_f : 0.5 in the PLA output format for an arbitrary W_OUT
package tanh_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_DRAIN  = 2'd2
  } state_e;

  function automatic int clog2_f(input int n);
    int r;
    r = 0;
    for (int v = n - 1; v > 0; v = v >> 1) r++;
    return (r == 0) ? 1 : r;
  endfunction

  // Output format has 2 integer bits, so 1.0 = 2^(W_OUT-2) and 0.5 = 2^(W_OUT-3).
  function automatic int one_half_f(input int w_out);
    return 1 << (w_out - 3);
  endfunction

  localparam int W_OUT_DEF = 10;
  localparam int ONE_HALF  = 1 << (W_OUT_DEF - 3);

endpackage

// File: rtl/pla_rsp_fifo.sv
// Response FIFO for the tanh PLA scheduler.
// Ports:
//   clk_i, rst_i      : clock, asynchronous active-high reset
//   wr_en_i, wr_data_i: push request and data (never issued while full)
//   rd_en_i           : pop request, ignored while empty
//   rd_data_o         : head entry, forced to zero while empty
//   full_o, empty_o   : occupancy flags
module pla_rsp_fifo
  import tanh_sched_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = 12
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             wr_en_i,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic             rd_en_i,
  output logic [WIDTH-1:0] rd_data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int PTR_W = clog2_f(DEPTH);
  localparam int CNT_W = clog2_f(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             do_wr, do_rd;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign do_wr   = wr_en_i && !full_o;
  assign do_rd   = rd_en_i && !empty_o;

  // Pointers wrap explicitly so DEPTH need not be a power of two.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_wr) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (do_rd) rd_ptr_q <= ptr_inc(rd_ptr_q);
      count_q <= count_q + CNT_W'(do_wr) - CNT_W'(do_rd);
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_wr) mem_q[wr_ptr_q] <= wr_data_i;
  end

  assign rd_data_o = empty_o ? '0 : mem_q[rd_ptr_q];

  // Credit-based issue upstream makes a write into a full FIFO impossible.
  a_no_overflow : assert property (@(posedge clk_i) disable iff (rst_i) !(wr_en_i && full_o));

endmodule

// File: rtl/tanh_pla_sched.sv
// Shares one registered tanh PLA among N_REQ requesters.
// Round-robin grant, registered issue stage, PLA_LAT-deep tag pipe carrying the
// requester ID, and a response FIFO guarded by issue credits.
// Ports:
//   clock, reset          : clock, asynchronous active-high reset
//   en                    : 1 = grant requests, 0 = stop granting and drain
//   req_valid/req_ready   : per-requester handshake (req_ready one-hot or zero)
//   req_data              : packed samples, requester i at [i*W_IN +: W_IN]
//   req_op                : (TANH_SCHED_SIGMOID_EN only) 0 = tanh, 1 = sigmoid
//   pla_in, pla_in_valid  : sample to the shared PLA
//   pla_out               : PLA result, PLA_LAT cycles after pla_in
//   rsp_valid/rsp_ready   : response FIFO head handshake
//   rsp_id, rsp_data      : requester ID and result at the FIFO head
//   idle                  : IDLE state, nothing in flight, FIFO empty
// Optional feature macro: TANH_SCHED_SIGMOID_EN adds req_op and sigmoid
// evaluation as sigmoid(x) = tanh(x/2)/2 + 1/2.
module tanh_pla_sched
  import tanh_sched_pkg::*;
#(
  parameter  int N_REQ      = 4,
  parameter  int W_IN       = 10,
  parameter  int W_OUT      = 10,
  parameter  int PLA_LAT    = 1,
  parameter  int FIFO_DEPTH = 4,
  localparam int ID_W       = clog2_f(N_REQ)
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    en,
  input  logic [N_REQ-1:0]        req_valid,
  output logic [N_REQ-1:0]        req_ready,
  input  logic [N_REQ*W_IN-1:0]   req_data,
`ifdef TANH_SCHED_SIGMOID_EN
  input  logic [N_REQ-1:0]        req_op,
`endif
  output logic [W_IN-1:0]         pla_in,
  output logic                    pla_in_valid,
  input  logic [W_OUT-1:0]        pla_out,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [ID_W-1:0]         rsp_id,
  output logic [W_OUT-1:0]        rsp_data,
  output logic                    idle
);

  localparam int                     CRD_W   = clog2_f(FIFO_DEPTH + 1);
  localparam logic [CRD_W-1:0]       CRD_MAX = CRD_W'(FIFO_DEPTH);
  localparam logic signed [W_OUT-1:0] HALF   = W_OUT'(one_half_f(W_OUT));

  state_e                 state_q, state_d;
  logic [ID_W-1:0]        ptr_q, ptr_d;
  logic [CRD_W-1:0]       credits_q, credits_d;
  logic                   idle_q;
  logic                   issue_ok, hs, pop, grant_found;
  logic [ID_W-1:0]        grant_id;
  logic signed [W_IN-1:0] raw_sample, issue_sample;

  logic [W_IN-1:0]        pla_in_q;
  logic                   pla_in_valid_q;
  logic [ID_W-1:0]        iss_id_q;
  logic                   tag_vld_q [PLA_LAT];
  logic [ID_W-1:0]        tag_id_q  [PLA_LAT];

  logic signed [W_OUT-1:0]   wr_result;
  logic [ID_W+W_OUT-1:0]     fifo_rd_data;
  logic                      fifo_empty, fifo_full;

`ifdef TANH_SCHED_SIGMOID_EN
  logic iss_op_q;
  logic tag_op_q [PLA_LAT];

  // Sigmoid argument is halved before the shared tanh PLA.
  function automatic logic signed [W_IN-1:0] sig_pre(input logic signed [W_IN-1:0] x);
    return x >>> 1;
  endfunction

  // Halve the tanh result and shift it up by 0.5.
  function automatic logic signed [W_OUT-1:0] sig_post(input logic signed [W_OUT-1:0] y);
    return (y >>> 1) + HALF;
  endfunction
`endif

  // Round-robin search: first valid index at or after the pointer, wrapping.
  always_comb begin
    int idx;
    grant_found = 1'b0;
    grant_id    = '0;
    idx         = 0;
    for (int off = 0; off < N_REQ; off++) begin
      idx = int'(ptr_q) + off;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (!grant_found && req_valid[idx]) begin
        grant_found = 1'b1;
        grant_id    = ID_W'(idx);
      end
    end
  end

  assign issue_ok  = (state_q == ST_ACTIVE) && (credits_q != '0);
  assign hs        = issue_ok && grant_found;
  assign req_ready = hs ? (N_REQ'(1) << grant_id) : '0;
  assign pop       = rsp_valid && rsp_ready;

  always_comb begin
    raw_sample   = req_data[int'(grant_id)*W_IN +: W_IN];
    issue_sample = raw_sample;
`ifdef TANH_SCHED_SIGMOID_EN
    if (req_op[grant_id]) issue_sample = sig_pre(raw_sample);
`endif
  end

  always_comb begin
    ptr_d = ptr_q;
    if (hs) ptr_d = (grant_id == ID_W'(N_REQ - 1)) ? '0 : grant_id + 1'b1;

    // A handshake consumes a credit, a pop returns one.
    credits_d = credits_q;
    if (hs && !pop)      credits_d = credits_q - 1'b1;
    else if (!hs && pop) credits_d = credits_q + 1'b1;

    // Full credits next cycle means nothing in flight and the FIFO empty.
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:   if (en) state_d = ST_ACTIVE;
      ST_ACTIVE: if (!en) state_d = ST_DRAIN;
      ST_DRAIN: begin
        if (en)                        state_d = ST_ACTIVE;
        else if (credits_d == CRD_MAX) state_d = ST_IDLE;
      end
      default:   state_d = ST_IDLE;
    endcase
  end

  // ---- issue stage: handshake at edge k drives pla_in during cycle k+1 ----
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q        <= ST_IDLE;
      ptr_q          <= '0;
      credits_q      <= CRD_MAX;
      idle_q         <= 1'b1;
      pla_in_q       <= '0;
      pla_in_valid_q <= 1'b0;
      iss_id_q       <= '0;
`ifdef TANH_SCHED_SIGMOID_EN
      iss_op_q       <= 1'b0;
`endif
    end else begin
      state_q        <= state_d;
      ptr_q          <= ptr_d;
      credits_q      <= credits_d;
      idle_q         <= (state_d == ST_IDLE) && (credits_d == CRD_MAX);
      pla_in_valid_q <= hs;
      if (hs) begin
        pla_in_q <= issue_sample;
        iss_id_q <= grant_id;
`ifdef TANH_SCHED_SIGMOID_EN
        iss_op_q <= req_op[grant_id];
`endif
      end
    end
  end

  // ---- tag pipe: last stage lines up with pla_out ----
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int s = 0; s < PLA_LAT; s++) begin
        tag_vld_q[s] <= 1'b0;
        tag_id_q[s]  <= '0;
`ifdef TANH_SCHED_SIGMOID_EN
        tag_op_q[s]  <= 1'b0;
`endif
      end
    end else begin
      tag_vld_q[0] <= pla_in_valid_q;
      tag_id_q[0]  <= iss_id_q;
`ifdef TANH_SCHED_SIGMOID_EN
      tag_op_q[0]  <= iss_op_q;
`endif
      for (int s = 1; s < PLA_LAT; s++) begin
        tag_vld_q[s] <= tag_vld_q[s-1];
        tag_id_q[s]  <= tag_id_q[s-1];
`ifdef TANH_SCHED_SIGMOID_EN
        tag_op_q[s]  <= tag_op_q[s-1];
`endif
      end
    end
  end

  // ---- response stage: PLA result enters the FIFO ----
  always_comb begin
    wr_result = pla_out;
`ifdef TANH_SCHED_SIGMOID_EN
    if (tag_op_q[PLA_LAT-1]) wr_result = sig_post(pla_out);
`endif
  end

  pla_rsp_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (ID_W + W_OUT)
  ) u_fifo (
    .clk_i     (clock),
    .rst_i     (reset),
    .wr_en_i   (tag_vld_q[PLA_LAT-1]),
    .wr_data_i ({tag_id_q[PLA_LAT-1], wr_result}),
    .rd_en_i   (rsp_ready),
    .rd_data_o (fifo_rd_data),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty)
  );

  assign rsp_valid    = !fifo_empty;
  assign rsp_id       = fifo_rd_data[W_OUT +: ID_W];
  assign rsp_data     = fifo_rd_data[W_OUT-1:0];
  assign pla_in       = pla_in_q;
  assign pla_in_valid = pla_in_valid_q;
  assign idle         = idle_q;

  // Credits account for the FIFO, so it can only be full with no credits left.
  a_full_no_credit : assert property (@(posedge clock) disable iff (reset)
                                      fifo_full |-> (credits_q == '0));

endmodule

// File: tb/tb_tanh_pla_sched.sv
// Bench for tanh_pla_sched with a registered identity stub as the PLA.
module tb_tanh_pla_sched;

  localparam int N_REQ = 4;
  localparam int W_IN  = 10;
  localparam int W_OUT = 10;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  en;
  logic [N_REQ-1:0]      req_valid;
  logic [N_REQ-1:0]      req_ready;
  logic [N_REQ*W_IN-1:0] req_data;
`ifdef TANH_SCHED_SIGMOID_EN
  logic [N_REQ-1:0]      req_op;
`endif
  logic [W_IN-1:0]       pla_in;
  logic                  pla_in_valid;
  logic [W_OUT-1:0]      pla_out;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [1:0]            rsp_id;
  logic [W_OUT-1:0]      rsp_data;
  logic                  idle;

  always #5 clk = ~clk;

  // PLA stub: identity, one register of latency.
  always_ff @(posedge clk) pla_out <= pla_in;

  tanh_pla_sched dut (
    .clock        (clk),
    .reset        (rst),
    .en           (en),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_data     (req_data),
`ifdef TANH_SCHED_SIGMOID_EN
    .req_op       (req_op),
`endif
    .pla_in       (pla_in),
    .pla_in_valid (pla_in_valid),
    .pla_out      (pla_out),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_id       (rsp_id),
    .rsp_data     (rsp_data),
    .idle         (idle)
  );

  typedef struct {
    int              id;
    logic            op;
    logic [W_IN-1:0] data;
    logic [W_IN-1:0] exp_pla;
    logic [W_OUT-1:0] exp_rsp;
  } vec_t;

  int n_checks = 0;
  int n_fail   = 0;
  int got_id[$];
  int got_data[$];
  int hs_cnt;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are read 3 units after it.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic collect();
    if (rsp_valid && rsp_ready) begin
      got_id.push_back(int'(rsp_id));
      got_data.push_back(int'(rsp_data));
    end
  endtask

  task automatic run_single(input vec_t v);
    next_cycle();
    req_valid = N_REQ'(1 << v.id);
    req_data  = '0;
    req_data[v.id*W_IN +: W_IN] = v.data;
`ifdef TANH_SCHED_SIGMOID_EN
    req_op = v.op ? N_REQ'(1 << v.id) : '0;
`endif
    settle();
    check("single_req_ready", 32'(req_ready), 32'(1 << v.id));
    next_cycle();
    req_valid = '0;
    settle();
    check("single_pla_in", 32'(pla_in), 32'(v.exp_pla));
    check("single_pla_in_valid", 32'(pla_in_valid), 32'd1);
    next_cycle();
    settle();
    check("single_pla_in_hold", 32'(pla_in), 32'(v.exp_pla));
    check("single_rsp_not_yet", 32'(rsp_valid), 32'd0);
    next_cycle();
    rsp_ready = 1'b1;
    settle();
    check("single_rsp_valid", 32'(rsp_valid), 32'd1);
    check("single_rsp_id", 32'(rsp_id), 32'(v.id));
    check("single_rsp_data", 32'(rsp_data), 32'(v.exp_rsp));
    next_cycle();
    rsp_ready = 1'b0;
    settle();
    check("single_rsp_popped", 32'(rsp_valid), 32'd0);
  endtask

  task automatic drain_all(input int cycles);
    req_valid = '0;
    rsp_ready = 1'b1;
    repeat (cycles) next_cycle();
    rsp_ready = 1'b0;
  endtask

  vec_t tbl[4];
`ifdef TANH_SCHED_SIGMOID_EN
  vec_t sig_tbl[3];
`endif

  initial begin
    // tanh vectors: the identity stub returns the sample unchanged.
    tbl[0] = '{id: 2, op: 1'b0, data: 10'h020, exp_pla: 10'h020, exp_rsp: 10'h020};
    tbl[1] = '{id: 0, op: 1'b0, data: 10'h1FF, exp_pla: 10'h1FF, exp_rsp: 10'h1FF};
    tbl[2] = '{id: 1, op: 1'b0, data: 10'h200, exp_pla: 10'h200, exp_rsp: 10'h200};
    tbl[3] = '{id: 3, op: 1'b0, data: 10'h000, exp_pla: 10'h000, exp_rsp: 10'h000};
`ifdef TANH_SCHED_SIGMOID_EN
    // sigmoid: pla_in = x>>>1, result = (pla_out>>>1) + 0x080.
    sig_tbl[0] = '{id: 1, op: 1'b1, data: 10'h000, exp_pla: 10'h000, exp_rsp: 10'h080};
    sig_tbl[1] = '{id: 2, op: 1'b1, data: 10'h080, exp_pla: 10'h040, exp_rsp: 10'h0A0};
    sig_tbl[2] = '{id: 0, op: 1'b1, data: 10'h380, exp_pla: 10'h3C0, exp_rsp: 10'h060};
    req_op = '0;
`endif

    rst       = 1'b1;
    en        = 1'b0;
    req_valid = '0;
    req_data  = '0;
    rsp_ready = 1'b0;
    repeat (2) @(posedge clk);
    #3;
    check("reset_req_ready", 32'(req_ready), 32'd0);
    check("reset_pla_in", 32'(pla_in), 32'd0);
    check("reset_pla_in_valid", 32'(pla_in_valid), 32'd0);
    check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    check("reset_rsp_id", 32'(rsp_id), 32'd0);
    check("reset_rsp_data", 32'(rsp_data), 32'd0);
    check("reset_idle", 32'(idle), 32'd1);

    next_cycle();
    rst = 1'b0;
    next_cycle();
    en = 1'b1;
    settle();
    check("idle_no_grant", 32'(req_ready), 32'd0);

    // Single-request vectors; the last one leaves the pointer at 0.
    for (int i = 0; i < 4; i++) run_single(tbl[i]);

    // Fairness: all requesters valid, consumer always ready.
    next_cycle();
    req_valid = '1;
    for (int i = 0; i < N_REQ; i++) req_data[i*W_IN +: W_IN] = W_IN'(16 * (i + 1));
    rsp_ready = 1'b1;
    got_id.delete();
    got_data.delete();
    for (int c = 0; c < 6; c++) begin
      if (c > 0) next_cycle();
      settle();
      check("fair_grant", 32'(req_ready), 32'(1 << (c % 4)));
      collect();
    end
    for (int c = 0; c < 6; c++) begin
      next_cycle();
      req_valid = '0;
      settle();
      collect();
    end
    rsp_ready = 1'b0;
    check("fair_rsp_count", 32'(got_id.size()), 32'd6);
    for (int k = 0; k < 6; k++) begin
      if (k < got_id.size()) begin
        check("fair_rsp_id", 32'(got_id[k]), 32'(k % 4));
        check("fair_rsp_data", 32'(got_data[k]), 32'(16 * ((k % 4) + 1)));
      end
    end

    // Backpressure: pointer is at 2, consumer stalled.
    next_cycle();
    req_valid = '1;
    hs_cnt = 0;
    for (int c = 0; c < 10; c++) begin
      if (c > 0) next_cycle();
      settle();
      hs_cnt += $countones(req_ready & req_valid);
    end
    check("bp_handshakes", 32'(hs_cnt), 32'd4);
    check("bp_stalled_ready", 32'(req_ready), 32'd0);
    next_cycle();
    rsp_ready = 1'b1;
    settle();
    check("bp_pulse_ready", 32'(req_ready), 32'd0);
    check("bp_pulse_head_id", 32'(rsp_id), 32'd2);
    next_cycle();
    rsp_ready = 1'b0;
    settle();
    check("bp_extra_grant", 32'(req_ready), 32'b0100);
    next_cycle();
    settle();
    check("bp_stalled_again", 32'(req_ready), 32'd0);
    drain_all(8);
    settle();
    check("bp_drained", 32'(rsp_valid), 32'd0);

    // Drain: pointer is at 3; two grants, then en drops.
    next_cycle();
    req_valid = '1;
    settle();
    check("drain_grant0", 32'(req_ready), 32'b1000);
    next_cycle();
    settle();
    check("drain_grant1", 32'(req_ready), 32'b0001);
    next_cycle();
    req_valid = '0;
    en = 1'b0;
    settle();
    check("drain_not_idle_c2", 32'(idle), 32'd0);
    next_cycle();
    req_valid = '1;
    rsp_ready = 1'b1;
    settle();
    check("drain_no_grant_c3", 32'(req_ready), 32'd0);
    check("drain_rsp_valid_c3", 32'(rsp_valid), 32'd1);
    check("drain_rsp_id_c3", 32'(rsp_id), 32'd3);
    check("drain_not_idle_c3", 32'(idle), 32'd0);
    next_cycle();
    settle();
    check("drain_no_grant_c4", 32'(req_ready), 32'd0);
    check("drain_rsp_id_c4", 32'(rsp_id), 32'd0);
    check("drain_not_idle_c4", 32'(idle), 32'd0);
    next_cycle();
    settle();
    check("drain_idle_c5", 32'(idle), 32'd1);
    check("drain_no_grant_c5", 32'(req_ready), 32'd0);
    check("drain_empty_c5", 32'(rsp_valid), 32'd0);
    next_cycle();
    req_valid = '0;
    rsp_ready = 1'b0;
    en = 1'b1;

    // Reset mid-operation: pointer is at 1; fill the FIFO with three entries.
    next_cycle();
    req_valid = '1;
    for (int c = 0; c < 3; c++) begin
      if (c > 0) next_cycle();
      settle();
      check("rst_fill_grant", 32'(req_ready), 32'(1 << (1 + c)));
    end
    next_cycle();
    req_valid = '0;
    next_cycle();
    next_cycle();
    settle();
    check("rst_fifo_loaded", 32'(rsp_valid), 32'd1);
    check("rst_fifo_head", 32'(rsp_id), 32'd1);
    rst = 1'b1;
    #1;
    check("rst_mid_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_mid_idle", 32'(idle), 32'd1);
    check("rst_mid_pla_in_valid", 32'(pla_in_valid), 32'd0);
    check("rst_mid_pla_in", 32'(pla_in), 32'd0);
    next_cycle();
    rst = 1'b0;
    req_valid = 4'b1010;
    settle();
    check("rst_release_idle_state", 32'(req_ready), 32'd0);
    next_cycle();
    settle();
    check("rst_first_grant", 32'(req_ready), 32'b0010);
    hs_cnt = 1;
    for (int c = 0; c < 7; c++) begin
      next_cycle();
      settle();
      hs_cnt += $countones(req_ready & req_valid);
    end
    check("rst_credits_full", 32'(hs_cnt), 32'd4);
    drain_all(8);
    settle();
    check("rst_drained", 32'(rsp_valid), 32'd0);

`ifdef TANH_SCHED_SIGMOID_EN
    for (int i = 0; i < 3; i++) run_single(sig_tbl[i]);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected end of test");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/tanh_pla_sched.md
Name: tanh_pla_sched

Overview:
- Shares one registered shift-based tanh PLA datapath among N_REQ requesters, e.g. LSTM gate lanes.
- Round-robin arbitration with a valid/ready handshake per requester; each accepted sample is tagged with its requester ID and carried through the PLA latency.
- Results are buffered in a response FIFO with valid/ready backpressure.
- Credit-based issue guarantees the FIFO never overflows.
- Sits between the gate accumulators and the shift PLA instance.

Parameters:
N_REQ, 4, number of requesters (>=2)
W_IN, 10, PLA input wordlength (Q4.6 at defaults)
W_OUT, 10, PLA output wordlength; format 2 integer bits incl. sign, so 1.0 = 2^(W_OUT-2)
PLA_LAT, 1, PLA register latency in cycles (>=1)
FIFO_DEPTH, 4, response FIFO entries (>=2)

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
en  in  1  1 = grant requests; 0 = stop granting and drain
req_valid  in  N_REQ  per-requester valid
req_ready  out  N_REQ  per-requester ready; one-hot or zero
req_data  in  N_REQ*W_IN  packed samples; requester i at [i*W_IN +: W_IN]
pla_in  out  W_IN  sample to shared PLA
pla_in_valid  out  1  pla_in holds an issued sample
pla_out  in  W_OUT  PLA result, valid PLA_LAT cycles after pla_in
rsp_valid  out  1  FIFO head valid
rsp_ready  in  1  consumer accepts head
rsp_id  out  ID_W  requester of head; ID_W = clog2(N_REQ)
rsp_data  out  W_OUT  result at head
idle  out  1  state IDLE, nothing in flight, FIFO empty

Behaviour:
- Reset values: rr pointer 0, credits FIFO_DEPTH, FIFO empty, tag pipe cleared.
  - Outputs: req_ready 0, pla_in 0, pla_in_valid 0, rsp_valid 0, rsp_id 0, rsp_data 0, idle 1.
  - Reset mid-operation discards all in-flight and buffered results.
- FSM states: IDLE, ACTIVE, DRAIN.
  - IDLE -> ACTIVE when en=1.
  - ACTIVE -> DRAIN when en=0.
  - DRAIN -> ACTIVE if en returns to 1.
  - DRAIN -> IDLE when tag pipe is empty and FIFO is empty.
- Issue condition: state ACTIVE, any req_valid, credits > 0.
- Grant rule: the first valid index at or after the pointer, wrapping modulo N_REQ.
  - req_ready is combinational from registered state and req_valid; it is not dependent on rsp_ready.
  - On handshake, pointer <= grant+1 mod N_REQ. Max one grant per cycle.
- Issue stage is registered: handshake at edge k gives pla_in / pla_in_valid during cycle k+1.
  - pla_in holds its last value when no sample is issued.
- Tag pipe: PLA_LAT-stage shift register of {valid, id}.
  - pla_out is written to the FIFO at edge k+1+PLA_LAT.
  - rsp_valid earliest in cycle k+2+PLA_LAT (3 cycles at defaults).
- FIFO pop on rsp_valid & rsp_ready. Order follows grant order.
- Credits:
  - Decrement on handshake; increment on pop; unchanged if both occur in the same cycle.
  - Invariant: credits + in-flight + occupancy = FIFO_DEPTH.
  - Write to a full FIFO is impossible; a simulation assertion flags it.
- A credit freed by a pop is usable from the next cycle.

Optional Feature:
Macro TANH_SCHED_SIGMOID_EN.
- With the macro:
  - Extra input port req_op, width N_REQ: 0 = tanh, 1 = sigmoid.
  - The op bit travels in the tag.
  - Sigmoid input is arithmetically shifted right by 1 before pla_in.
  - Sigmoid result written to the FIFO = (pla_out >>> 1) + ONE_HALF, where ONE_HALF = 2^(W_OUT-3).
- Without the macro: no req_op port; all requests are tanh; pla_out is stored unmodified.

Decomposition:
- Package tanh_sched_pkg holds: FSM state encoding, clog2 function for ID_W, ONE_HALF constant.
- One sub-module, pla_rsp_fifo: synchronous FIFO, parameters DEPTH and WIDTH = ID_W+W_OUT, with full/empty flags and async active-high reset.
- Arbiter, credits, FSM and tag pipe stay in the top module.

Test Plan:
- Bench stub PLA: registered identity, PLA_LAT=1, pla_out = pla_in delayed one cycle.
- Single request: en=1, req_valid=4'b0100, data 10'b0000_100000 at cycle 0.
  - req_ready=4'b0100 in cycle 0.
  - pla_in=0x020 and pla_in_valid=1 in cycle 1.
  - rsp_valid=1, rsp_id=2, rsp_data=0x020 in cycle 3.
- Fairness: all four req_valid held high, rsp_ready=1.
  - Grants 0,1,2,3,0,1 on consecutive cycles; rsp_id sequence identical.
- Backpressure: all valid, rsp_ready=0.
  - Exactly 4 handshakes, then req_ready=0 indefinitely.
  - One-cycle rsp_ready pulse yields exactly one further grant in the next cycle.
- Drain: en drops with 2 samples in flight.
  - No further grants; state DRAIN.
  - idle rises the cycle after the second response is popped.
- Reset mid-operation: reset asserted with FIFO holding 3 entries.
  - rsp_valid=0 immediately.
  - After release: credits 4, first grant to the lowest-index valid requester.
- TANH_SCHED_SIGMOID_EN: req_op=1, data 0x000 -> pla_in 0x000, rsp_data 0x080 (0.5).
  - req_op=1, data 0x080 -> pla_in 0x040.
